// File: rtl/arp_rx_pkg.sv
// rtl/arp_rx_pkg.sv - shared Ethernet/ARP codes and one-hot state encoding for arp_rx
package arp_rx_pkg;

    localparam logic [7:0]  CODE_PREAMBLE = 8'h55;
    localparam logic [7:0]  CODE_SFD      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

    localparam logic [5:0] PRE_LAST  = 6'd6;
    localparam logic [5:0] DMAC_LAST = 6'd5;
    localparam logic [5:0] ETH_LAST  = 6'd13;
    localparam logic [5:0] OP_LAST   = 6'd7;
    localparam logic [5:0] SMAC_FIRST = 6'd8;
    localparam logic [5:0] SMAC_LAST = 6'd13;
    localparam logic [5:0] SIP_FIRST = 6'd14;
    localparam logic [5:0] SIP_LAST  = 6'd17;
    localparam logic [5:0] ARP_LAST  = 6'd27;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_PREAMBLE = 5'b00010,
        ST_ETH_HEAD = 5'b00100,
        ST_ARP_DATA = 5'b01000,
        ST_RX_END   = 5'b10000
    } state_t;

endpackage

// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - GMII ARP receive parser: validates frame, pulses done with sender MAC/IP/op
module arp_rx
    import arp_rx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [47:0] mac_tmp_q, mac_tmp_d;
    logic [31:0] ip_tmp_q, ip_tmp_d;
    logic        type_tmp_q, type_tmp_d;
    logic        done_q, done_d;
    logic        type_q, type_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;

    logic [47:0] dmac_w;
    logic [15:0] half_w;
    logic [31:0] tip_w;

    // Multi-byte fields are completed by the live byte so checks fire on their last byte.
    assign dmac_w = {shift_q[39:0], gmii_rxd};
    assign half_w = {shift_q[7:0], gmii_rxd};
    assign tip_w  = {shift_q[23:0], gmii_rxd};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        mac_tmp_d  = mac_tmp_q;
        ip_tmp_d   = ip_tmp_q;
        type_tmp_d = type_tmp_q;
        done_d     = 1'b0;
        type_d     = type_q;
        src_mac_d  = src_mac_q;
        src_ip_d   = src_ip_q;

        if (!gmii_rx_dv) begin
            state_d = ST_IDLE;
        end else begin
            shift_d = {shift_q[31:0], gmii_rxd};
            unique case (state_q)
                ST_IDLE: begin
                    if (gmii_rxd == CODE_PREAMBLE) state_d = ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    if (cnt_q < PRE_LAST) begin
                        if (gmii_rxd != CODE_PREAMBLE) state_d = ST_RX_END;
                    end else if (gmii_rxd == CODE_SFD) begin
                        state_d = ST_ETH_HEAD;
                    end else begin
                        state_d = ST_RX_END;
                    end
                end
                ST_ETH_HEAD: begin
                    if (cnt_q == DMAC_LAST) begin
                        if (dmac_w != BOARD_MAC && dmac_w != MAC_BROADCAST) state_d = ST_RX_END;
                    end else if (cnt_q == ETH_LAST) begin
                        state_d = (half_w == ETH_TYPE_ARP) ? ST_ARP_DATA : ST_RX_END;
                    end
                end
                ST_ARP_DATA: begin
                    if (cnt_q == OP_LAST) begin
                        if (half_w == ARP_OP_REQ)        type_tmp_d = 1'b0;
                        else if (half_w == ARP_OP_REPLY) type_tmp_d = 1'b1;
                        else                             state_d    = ST_RX_END;
                    end else if (cnt_q >= SMAC_FIRST && cnt_q <= SMAC_LAST) begin
                        mac_tmp_d = {mac_tmp_q[39:0], gmii_rxd};
                    end else if (cnt_q >= SIP_FIRST && cnt_q <= SIP_LAST) begin
                        ip_tmp_d = {ip_tmp_q[23:0], gmii_rxd};
                    end else if (cnt_q == ARP_LAST) begin
                        state_d = ST_RX_END;
                        if (tip_w == BOARD_IP) begin
                            done_d    = 1'b1;
                            type_d    = type_tmp_q;
                            src_mac_d = mac_tmp_q;
                            src_ip_d  = ip_tmp_q;
                        end
                    end
                end
                ST_RX_END: ;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) cnt_d = 6'd0;
        else if (gmii_rx_dv)    cnt_d = cnt_q + 6'd1;
        else                    cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            shift_q    <= 40'd0;
            mac_tmp_q  <= 48'd0;
            ip_tmp_q   <= 32'd0;
            type_tmp_q <= 1'b0;
            done_q     <= 1'b0;
            type_q     <= 1'b0;
            src_mac_q  <= 48'd0;
            src_ip_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            mac_tmp_q  <= mac_tmp_d;
            ip_tmp_q   <= ip_tmp_d;
            type_tmp_q <= type_tmp_d;
            done_q     <= done_d;
            type_q     <= type_d;
            src_mac_q  <= src_mac_d;
            src_ip_q   <= src_ip_d;
        end
    end

    assign arp_rx_done = done_q;
    assign arp_rx_type = type_q;
    assign src_mac     = src_mac_q;
    assign src_ip      = src_ip_q;

endmodule
